mdom_wvb_hdr_serializer: RTL and testbench

- Consumer end of the 104-bit waveform-buffer header bundle.
- Pops one bundle per event from a first-word-fall-through (FWFT) header FIFO and unpacks its fields.
- Emits the header as a fixed sequence of 16-bit words on a valid/ready stream toward the readout/event-builder mux.
- Inverse of the header fan-in packing.

---
 rtl/mdom_wvb_hdr_serializer.sv | 129 ++++++++++++
 tb/tb_mdom_wvb_hdr_serializer.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdom_wvb_hdr_serializer.sv
// Pops 104-bit waveform-buffer header bundles from an FWFT FIFO and streams them as 16-bit words.
// Define MDOM_WVB_HDR_SER_BSUM_EN to carry the baseline sum (10-word header instead of 8).
module mdom_wvb_hdr_serializer #(
    parameter logic [2:0] CHAN_ID = 3'd0,
    parameter logic [3:0] MARKER  = 4'hE
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [103:0] hdr_bundle,
    input  logic         hdr_empty,
    output logic         hdr_rdreq,
    output logic [15:0]  dout,
    output logic         dout_valid,
    input  logic         dout_ready,
    output logic         dout_sof,
    output logic         dout_eof,
    output logic         busy,
    output logic [15:0]  hdr_cnt
);

`ifdef MDOM_WVB_HDR_SER_BSUM_EN
    localparam logic [3:0] LAST = 4'd9;
`else
    localparam logic [3:0] LAST = 4'd7;
`endif

    typedef enum logic [1:0] {IDLE, POP, SEND} state_t;

    state_t        state;
    logic [3:0]    idx;
    logic [103:0]  bundle_q;
    logic [103:0]  src;
    logic [3:0]    nxt_idx;
    logic [15:0]   nxt_word;
    logic [10:0]   nsamp;
    logic [3:0]    bsum_lo;
    logic [15:0]   w8;
    logic [15:0]   w9;

    // Word 0 is built straight from the FIFO head in the pop cycle.
    assign src     = (state == POP) ? hdr_bundle : bundle_q;
    assign nxt_idx = (state == POP) ? 4'd0 : idx + 4'd1;
    assign nsamp   = src[70:60] - src[59:49] + 11'd1;

`ifdef MDOM_WVB_HDR_SER_BSUM_EN
    assign bsum_lo = {src[102], src[101:99]};
    assign w8      = {13'b0, src[98:96]};
    assign w9      = src[95:80];
`else
    logic unused_bsum;
    assign unused_bsum = ^src[102:80];
    assign bsum_lo     = 4'd0;
    assign w8          = 16'h0;
    assign w9          = 16'h0;
`endif

    always_comb begin
        nxt_word = 16'h0;
        case (nxt_idx)
            4'd0: nxt_word = {MARKER, CHAN_ID, src[72:71], src[73],
                              src[79], src[103], bsum_lo};
            4'd1: nxt_word = {src[78:74], nsamp};
            4'd2: nxt_word = {15'b0, src[48]};
            4'd3: nxt_word = src[47:32];
            4'd4: nxt_word = src[31:16];
            4'd5: nxt_word = src[15:0];
            4'd6: nxt_word = {5'b0, src[59:49]};
            4'd7: nxt_word = {5'b0, src[70:60]};
            4'd8: nxt_word = w8;
            4'd9: nxt_word = w9;
            default: nxt_word = 16'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= 4'd0;
            bundle_q   <= '0;
            hdr_rdreq  <= 1'b0;
            dout       <= 16'h0;
            dout_valid <= 1'b0;
            dout_sof   <= 1'b0;
            dout_eof   <= 1'b0;
            busy       <= 1'b0;
            hdr_cnt    <= 16'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (en && !hdr_empty) begin
                        hdr_rdreq <= 1'b1;
                        busy      <= 1'b1;
                        state     <= POP;
                    end
                end
                POP: begin
                    hdr_rdreq  <= 1'b0;
                    bundle_q   <= hdr_bundle;
                    idx        <= 4'd0;
                    dout       <= nxt_word;
                    dout_valid <= 1'b1;
                    dout_sof   <= 1'b1;
                    dout_eof   <= 1'b0;
                    state      <= SEND;
                end
                SEND: begin
                    if (dout_ready) begin
                        if (idx == LAST) begin
                            dout_valid <= 1'b0;
                            dout_sof   <= 1'b0;
                            dout_eof   <= 1'b0;
                            busy       <= 1'b0;
                            hdr_cnt    <= hdr_cnt + 16'd1;
                            state      <= IDLE;
                        end else begin
                            idx      <= nxt_idx;
                            dout     <= nxt_word;
                            dout_sof <= 1'b0;
                            dout_eof <= (nxt_idx == LAST);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdom_wvb_hdr_serializer.sv
// Scoreboard bench for mdom_wvb_hdr_serializer: FWFT FIFO model, randomized bundles, reference model.
// Honors MDOM_WVB_HDR_SER_BSUM_EN the same way as the design.
module tb_mdom_wvb_hdr_serializer;

`ifdef MDOM_WVB_HDR_SER_BSUM_EN
    localparam int HLEN = 10;
    localparam logic [15:0] T1_W0 = 16'hE10B;
`else
    localparam int HLEN = 8;
    localparam logic [15:0] T1_W0 = 16'hE100;
`endif

    typedef struct packed {
        logic [15:0] w;
        logic        sof;
        logic        eof;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         en;
    logic [103:0] hdr_bundle;
    logic         hdr_empty;
    logic         hdr_rdreq;
    logic [15:0]  dout;
    logic         dout_valid;
    logic         dout_ready;
    logic         dout_sof;
    logic         dout_eof;
    logic         busy;
    logic [15:0]  hdr_cnt;

    int checks = 0;
    int errors = 0;

    logic [103:0] fifo [$];
    exp_t         exp_q [$];
    logic [15:0]  last_hdr [10];
    int           model_cnt = 0;
    int           hdr_pos = 0;
    int           pops = 0;
    int           words = 0;
    int           hdrs_sent = 0;

    mdom_wvb_hdr_serializer #(.CHAN_ID(3'd0), .MARKER(4'hE)) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .hdr_bundle(hdr_bundle), .hdr_empty(hdr_empty), .hdr_rdreq(hdr_rdreq),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .dout_sof(dout_sof), .dout_eof(dout_eof),
        .busy(busy), .hdr_cnt(hdr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic chk_true(input string name, input bit ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=0 required=1", name);
        end
    endtask

    // Reference: header words derived arithmetically from the field map.
    function automatic logic [9:0][15:0] ref_hdr(input logic [103:0] b);
        logic [9:0][15:0] w;
        longint ltc;
        int sa, ea, n, ts, cr, pc, sr, bs, bl, bv, lc, lo;
        ltc = longint'(b[48:0]);
        sa  = int'(b[59:49]);
        ea  = int'(b[70:60]);
        ts  = int'(b[72:71]);
        cr  = int'(b[73]);
        pc  = int'(b[78:74]);
        sr  = int'(b[79]);
        bs  = int'(b[98:80]);
        bl  = int'(b[101:99]);
        bv  = int'(b[102]);
        lc  = int'(b[103]);
        n   = (((ea - sa + 1) % 2048) + 2048) % 2048;
        lo  = (HLEN == 10) ? (bv * 8 + bl) : 0;
        w[0] = 16'(14 * 4096 + 0 * 512 + ts * 128 + cr * 64 + sr * 32 + lc * 16 + lo);
        w[1] = 16'(pc * 2048 + n);
        w[2] = 16'(ltc >> 48);
        w[3] = 16'((ltc >> 32) % 65536);
        w[4] = 16'((ltc >> 16) % 65536);
        w[5] = 16'(ltc % 65536);
        w[6] = 16'(sa);
        w[7] = 16'(ea);
        w[8] = 16'(bs / 65536);
        w[9] = 16'(bs % 65536);
        return w;
    endfunction

    function automatic logic [103:0] mk(input logic [48:0] ltc, input logic [10:0] sa,
                                        input logic [10:0] ea, input logic [1:0] ts,
                                        input logic [4:0] pc, input logic [18:0] bs,
                                        input logic [2:0] bl, input logic bv);
        logic [103:0] b;
        b = '0;
        b[48:0]   = ltc;
        b[59:49]  = sa;
        b[70:60]  = ea;
        b[72:71]  = ts;
        b[78:74]  = pc;
        b[98:80]  = bs;
        b[101:99] = bl;
        b[102]    = bv;
        return b;
    endfunction

    function automatic logic [103:0] rnd_bundle();
        logic [127:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom()};
        return r[103:0];
    endfunction

    task automatic push_exp(input logic [103:0] b);
        logic [9:0][15:0] w;
        exp_t e;
        w = ref_hdr(b);
        for (int i = 0; i < HLEN; i++) begin
            e.w   = w[i];
            e.sof = (i == 0);
            e.eof = (i == HLEN - 1);
            exp_q.push_back(e);
        end
    endtask

    // FWFT FIFO model; a pop issues the expected words for that header.
    initial begin
        logic p;
        logic [103:0] b;
        hdr_empty  = 1'b1;
        hdr_bundle = '0;
        forever begin
            @(negedge clk);
            p = hdr_rdreq;
            @(posedge clk);
            #1;
            if (p) begin
                chk_true("pop_nonempty", fifo.size() != 0);
                if (fifo.size() != 0) begin
                    b = fifo.pop_front();
                    if (rst_n) push_exp(b);
                end
            end
            hdr_empty  = (fifo.size() == 0);
            hdr_bundle = hdr_empty ? '0 : fifo[0];
        end
    end

    // Monitor: scoreboard compare, hold-under-stall, pop spacing, busy and count.
    initial begin
        bit stall, prev_rd, prev_vld;
        logic [15:0] st_w;
        logic st_sof, st_eof;
        exp_t e;
        stall = 0; prev_rd = 0; prev_vld = 0;
        st_w = '0; st_sof = 0; st_eof = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                model_cnt = 0;
                hdr_pos   = 0;
                stall     = 0;
                prev_rd   = 0;
                prev_vld  = 0;
            end else begin
                chk("hdr_cnt", 64'(hdr_cnt), 64'(model_cnt));
                chk("busy", 64'(busy), 64'(dout_valid | hdr_rdreq));
                if (stall) begin
                    chk("hold_valid", 64'(dout_valid), 64'(1));
                    chk("hold_dout", 64'(dout), 64'(st_w));
                    chk("hold_sofeof", 64'({dout_sof, dout_eof}), 64'({st_sof, st_eof}));
                end
                if (hdr_rdreq) begin
                    pops++;
                    chk("rdreq_spacing", 64'({prev_rd, prev_vld, dout_valid}), 64'(0));
                end
                if (dout_valid && dout_ready) begin
                    chk_true("word_expected", exp_q.size() != 0);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("dout", 64'(dout), 64'(e.w));
                        chk("sof_eof", 64'({dout_sof, dout_eof}), 64'({e.sof, e.eof}));
                        last_hdr[hdr_pos] = dout;
                        hdr_pos++;
                        words++;
                        if (e.eof) begin
                            model_cnt++;
                            hdr_pos = 0;
                        end
                    end
                end
                stall    = dout_valid && !dout_ready;
                st_w     = dout;
                st_sof   = dout_sof;
                st_eof   = dout_eof;
                prev_rd  = hdr_rdreq;
                prev_vld = dout_valid;
            end
        end
    end

    task automatic drain(input int maxc, input bit rnd);
        int c;
        c = 0;
        repeat (2) @(negedge clk);
        while (((fifo.size() != 0) && en) || (exp_q.size() != 0) || busy) begin
            @(posedge clk);
            #1;
            if (rnd) dout_ready = ($urandom_range(3) != 0);
            @(negedge clk);
            c++;
            if (c > maxc) break;
        end
        @(posedge clk);
        #1;
        dout_ready = 1'b1;
        chk_true("drain_timeout", c <= maxc);
    endtask

    task automatic wait_pos(input int p, input string nm);
        int c;
        c = 0;
        do begin
            @(negedge clk);
            #2;
            c++;
        end while (hdr_pos != p && c < 500);
        chk_true(nm, hdr_pos == p);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, w0, c;
        logic [103:0] b;
        logic [15:0] w1;
        rst_n = 1'b0;
        en = 1'b0;
        dout_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rdreq", 64'(hdr_rdreq), 64'(0));
        chk("rst_valid", 64'(dout_valid), 64'(0));
        chk("rst_sof_eof", 64'({dout_sof, dout_eof}), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_dout", 64'(dout), 64'(0));
        chk("rst_cnt", 64'(hdr_cnt), 64'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed header
        fifo.push_back(mk(49'h1_2345_6789_ABCD, 11'h010, 11'h02F, 2'd2, 5'd5,
                          19'h7_1234, 3'd3, 1'b1));
        en = 1'b1;
        drain(300, 1'b0);
        hdrs_sent++;
        chk("t1_w0", 64'(last_hdr[0]), 64'(T1_W0));
        chk("t1_w1", 64'(last_hdr[1]), 64'h2820);
        chk("t1_w2", 64'(last_hdr[2]), 64'h0001);
        chk("t1_w3", 64'(last_hdr[3]), 64'h2345);
        chk("t1_w4", 64'(last_hdr[4]), 64'h6789);
        chk("t1_w5", 64'(last_hdr[5]), 64'hABCD);
        chk("t1_w6", 64'(last_hdr[6]), 64'h0010);
        chk("t1_w7", 64'(last_hdr[7]), 64'h002F);
`ifdef MDOM_WVB_HDR_SER_BSUM_EN
        chk("t1_w8", 64'(last_hdr[8]), 64'h0007);
        chk("t1_w9", 64'(last_hdr[9]), 64'h1234);
`endif
        chk("t1_cnt", 64'(hdr_cnt), 64'(hdrs_sent));
        chk("t1_pops", 64'(pops), 64'(1));

        // Sample-count wrap cases
        b = rnd_bundle();
        b[59:49] = 11'h7F0;
        b[70:60] = 11'h00F;
        fifo.push_back(b);
        drain(300, 1'b0);
        hdrs_sent++;
        w1 = last_hdr[1];
        chk("wrap_nsamp_20", 64'(w1[10:0]), 64'h020);
        b = rnd_bundle();
        b[59:49] = 11'h005;
        b[70:60] = 11'h004;
        fifo.push_back(b);
        drain(300, 1'b0);
        hdrs_sent++;
        w1 = last_hdr[1];
        chk("wrap_nsamp_0", 64'(w1[10:0]), 64'h000);

        // Backpressure at W4 for three cycles
        fifo.push_back(rnd_bundle());
        wait_pos(4, "bp_reach_w4");
        @(posedge clk);
        #1;
        dout_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        dout_ready = 1'b1;
        drain(300, 1'b0);
        hdrs_sent++;
        chk("bp_cnt", 64'(hdr_cnt), 64'(hdrs_sent));

        // Three queued headers back to back
        p0 = pops;
        w0 = words;
        repeat (3) fifo.push_back(rnd_bundle());
        drain(500, 1'b0);
        hdrs_sent += 3;
        chk("q3_pops", 64'(pops - p0), 64'(3));
        chk("q3_words", 64'(words - w0), 64'(3 * HLEN));
        chk("q3_cnt", 64'(hdr_cnt), 64'(hdrs_sent));

        // en dropped during the 2nd of three headers
        p0 = pops;
        repeat (3) fifo.push_back(rnd_bundle());
        c = 0;
        do begin
            @(negedge clk);
            #2;
            c++;
        end while (pops < p0 + 2 && c < 500);
        chk_true("en_reach_2nd", pops == p0 + 2);
        @(posedge clk);
        #1;
        en = 1'b0;
        drain(500, 1'b0);
        repeat (5) @(negedge clk);
        hdrs_sent += 2;
        chk("en_pops", 64'(pops - p0), 64'(2));
        chk("en_fifo_left", 64'(fifo.size()), 64'(1));
        chk("en_cnt", 64'(hdr_cnt), 64'(hdrs_sent));
        en = 1'b1;
        drain(300, 1'b0);
        hdrs_sent++;
        chk("en_pops_after", 64'(pops - p0), 64'(3));

        // Randomized headers with random backpressure
        for (int i = 0; i < 20; i++) fifo.push_back(rnd_bundle());
        drain(4000, 1'b1);
        hdrs_sent += 20;
        chk("rnd_cnt", 64'(hdr_cnt), 64'(hdrs_sent));

        // Reset at W5: header dropped, next FIFO entry sent whole
        fifo.push_back(rnd_bundle());
        fifo.push_back(rnd_bundle());
        wait_pos(5, "rst_reach_w5");
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_valid", 64'(dout_valid), 64'(0));
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("midrst_cnt", 64'(hdr_cnt), 64'(0));
        chk("midrst_fifo", 64'(fifo.size()), 64'(1));
        p0 = pops;
        drain(300, 1'b0);
        chk("midrst_pops", 64'(pops - p0), 64'(1));
        chk("midrst_cnt_after", 64'(hdr_cnt), 64'(1));
        chk("exp_q_empty", 64'(exp_q.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
